// File: rtl/dvbc_pkg.sv
// Shared DVB-C modulator definitions: QAM mode encodings, symbol width and the
// mode -> bits-per-symbol mapping used by the symbol builder and the QAM mapper.
package dvbc_pkg;

    localparam int SYM_W = 8;

    typedef enum logic [2:0] {
        QAM16  = 3'd0,
        QAM32  = 3'd1,
        QAM64  = 3'd2,
        QAM128 = 3'd3,
        QAM256 = 3'd4
    } qam_mode_e;

    function automatic logic [3:0] bits_per_symbol(input qam_mode_e mode);
        logic [3:0] m;
        case (mode)
            QAM16:   m = 4'd4;
            QAM32:   m = 4'd5;
            QAM64:   m = 4'd6;
            QAM128:  m = 4'd7;
            default: m = 4'd8;
        endcase
        return m;
    endfunction

    // Reserved encodings 5..7 fold onto 256-QAM.
    function automatic qam_mode_e normalize_mode(input logic [2:0] raw_mode);
        return (raw_mode > 3'd4) ? QAM256 : qam_mode_e'(raw_mode);
    endfunction

endpackage

// File: rtl/dvbc_diff_encoder.sv
// Combinational differential encoder for the two MSBs of a DVB-C symbol:
// (A_k, B_k, I_prev, Q_prev) -> (I_k, Q_k).
module dvbc_diff_encoder (
    input  logic a,
    input  logic b,
    input  logic i_prev,
    input  logic q_prev,
    output logic i,
    output logic q
);

    logic ab_diff;

    // Equal MSBs rotate against the same-axis history, unequal ones cross over.
    assign ab_diff = a ^ b;
    assign i = (~ab_diff & (a ^ i_prev)) | (ab_diff & (a ^ q_prev));
    assign q = (~ab_diff & (b ^ q_prev)) | (ab_diff & (b ^ i_prev));

endmodule

// File: rtl/dvbc_symbol_builder.sv
// Byte-to-symbol converter for the DVB-C modulator: packs the interleaved byte
// stream into m-bit symbols MSB first and differentially encodes the two MSBs.
module dvbc_symbol_builder
    import dvbc_pkg::*;
#(
    parameter bit SIMULATION = 1'b0,
    parameter bit DEBUG      = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       qam_mode_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic [SYM_W-1:0] sym_o,
    output logic             sym_valid_o,
    input  logic             sym_ready_i,
    output logic [4:0]       dbg_fill_o
);

    logic [15:0]      acc_q;
    logic [15:0]      acc_d;
    logic [4:0]       fill_q;
    logic [4:0]       fill_d;
    logic [4:0]       fill_pop;
    qam_mode_e        mode_q;
    logic             i_prev_q;
    logic             q_prev_q;
    logic             i_new;
    logic             q_new;
    logic [SYM_W-1:0] sym_q;
    logic [SYM_W-1:0] sym_d;
    logic [SYM_W-1:0] raw;
    logic [SYM_W-1:0] low_mask;
    logic [SYM_W-1:0] iq_bits;
    logic             sym_valid_q;
    logic [3:0]       m;
    logic             accept;
    logic             pop;

    assign m            = bits_per_symbol(mode_q);
    assign byte_ready_o = (fill_q <= 5'd8);
    assign accept       = byte_valid_i && byte_ready_o;
    assign pop          = (fill_q >= {1'b0, m}) && (!sym_valid_q || sym_ready_i);

    dvbc_diff_encoder u_diff (
        .a      (acc_q[15]),
        .b      (acc_q[14]),
        .i_prev (i_prev_q),
        .q_prev (q_prev_q),
        .i      (i_new),
        .q      (q_new)
    );

    // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        fill_pop = fill_q;
        acc_d    = acc_q;
        if (pop) begin
            fill_pop = fill_q - {1'b0, m};
            acc_d    = acc_q << m;
        end
        fill_d = fill_pop;
        if (accept) begin
            // The new byte lands directly below the bits that survive this edge's pop.
            acc_d  = acc_d | ({8'h00, byte_i} << (5'd8 - fill_pop));
            fill_d = fill_pop + 5'd8;
        end
    end

    always_comb begin
        raw      = acc_q[15:8] >> (4'd8 - m);
        low_mask = (8'd1 << (m - 4'd2)) - 8'd1;
        iq_bits  = {{(SYM_W - 2){1'b0}}, i_new, q_new};
        sym_d    = (iq_bits << (m - 4'd2)) | (raw & low_mask);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            fill_q      <= '0;
            mode_q      <= QAM256;
            i_prev_q    <= 1'b0;
            q_prev_q    <= 1'b0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            if (pop) begin
                sym_q       <= sym_d;
                sym_valid_q <= 1'b1;
                i_prev_q    <= i_new;
                q_prev_q    <= q_new;
            end else if (sym_ready_i) begin
                sym_valid_q <= 1'b0;
            end
            // Mode only switches when nothing is buffered, so no symbol straddles two modes.
            if (fill_q == 5'd0 && !sym_valid_q) begin
                mode_q <= normalize_mode(qam_mode_i);
            end
        end
    end

    assign sym_o       = sym_q;
    assign sym_valid_o = sym_valid_q;
    assign dbg_fill_o  = DEBUG ? fill_q : 5'd0;

    if (SIMULATION) begin : g_sim_checks
        a_byte_hold : assert property (@(posedge clk_i) disable iff (rst_i)
            (byte_valid_i && !byte_ready_o) |=> (byte_valid_i && $stable(byte_i)))
            else $error("dvbc_symbol_builder: byte_valid_i/byte_i changed while stalled");
    end

endmodule

// File: tb/tb_dvbc_symbol_builder.sv
// Self-checking bench for dvbc_symbol_builder: fixed vectors, multi-cycle corner
// sequences and randomized streams checked against a bit-queue reference model.
module tb_dvbc_symbol_builder;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] qam_mode_i;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       byte_ready_o;
    logic [7:0] sym_o;
    logic       sym_valid_o;
    logic       sym_ready_i;
    logic [4:0] dbg_fill_o;

    always #5 clk_i = ~clk_i;

    dvbc_symbol_builder #(
        .SIMULATION (1'b0),
        .DEBUG      (1'b1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .qam_mode_i   (qam_mode_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .sym_o        (sym_o),
        .sym_valid_o  (sym_valid_o),
        .sym_ready_i  (sym_ready_i),
        .dbg_fill_o   (dbg_fill_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain bit queue consumed m bits at a time.
    bit         model_bits[$];
    bit         model_i;
    bit         model_q;
    int         model_m = 8;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    function automatic int m_of(input logic [2:0] mode);
        return (mode >= 3'd4) ? 8 : 4 + int'(mode);
    endfunction

    task automatic model_reset();
        model_bits.delete();
        model_i = 1'b0;
        model_q = 1'b0;
        model_m = 8;
    endtask

    task automatic model_feed(input logic [7:0] b);
        bit a;
        bit bb;
        bit ni;
        bit nq;
        int v;
        for (int k = 7; k >= 0; k--) model_bits.push_back(b[k]);
        while (model_bits.size() >= model_m) begin
            a  = model_bits.pop_front();
            bb = model_bits.pop_front();
            if (a == bb) begin
                ni = a ^ model_i;
                nq = bb ^ model_q;
            end else begin
                ni = a ^ model_q;
                nq = bb ^ model_i;
            end
            v = 2 * int'(ni) + int'(nq);
            for (int k = 0; k < model_m - 2; k++) v = 2 * v + int'(model_bits.pop_front());
            exp_q.push_back(v[7:0]);
            model_i = ni;
            model_q = nq;
        end
    endtask

    task automatic do_reset();
        rst_i        = 1'b1;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        sym_ready_i  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        model_reset();
    endtask

    task automatic set_mode(input logic [2:0] mode);
        qam_mode_i  = mode;
        sym_ready_i = 1'b1;
        if (model_bits.size() == 0) model_m = m_of(mode);
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_q.push_back(b);
        model_feed(b);
    endtask

    // Drives tx_q, collects symbols and compares them in order against exp_q.
    task automatic run_stream(input int vpct, input int rpct, input int stall, input bit chk_rdy,
                              output int first_cyc, output int last_cyc);
        int         idx = 0;
        int         cyc = 0;
        int         n_got = 0;
        int         n_exp;
        int         budget;
        bit         accepted;
        bit         hold = 1'b0;
        bit         rdy_low = 1'b0;
        bit         done = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] e;
        n_exp     = exp_q.size();
        budget    = 200 + 40 * tx_q.size();
        first_cyc = -1;
        last_cyc  = -1;
        while (!done && cyc < budget) begin
            if (!byte_valid_i && idx < tx_q.size() && $urandom_range(99) < vpct) begin
                byte_i       = tx_q[idx];
                byte_valid_i = 1'b1;
            end
            sym_ready_i = (cyc >= stall) && ($urandom_range(99) < rpct);
            @(negedge clk_i);
            if (hold) begin
                check("hold_valid", sym_valid_o, 1);
                check("hold_data", sym_o, held);
            end
            if (chk_rdy && !byte_ready_o) rdy_low = 1'b1;
            if (stall > 0 && cyc == stall - 1) begin
                check("bp_byte_ready", byte_ready_o, 0);
                check("bp_fill", dbg_fill_o, 12);
                check("bp_sym_valid", sym_valid_o, 1);
            end
            accepted = byte_valid_i && byte_ready_o;
            if (sym_valid_o && sym_ready_i) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_got++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sym", sym_o, e);
                end
            end
            hold = sym_valid_o && !sym_ready_i;
            held = sym_o;
            @(posedge clk_i);
            #1;
            if (accepted) begin
                byte_valid_i = 1'b0;
                idx++;
            end
            cyc++;
            done = (idx == tx_q.size()) && (n_got == n_exp) && !sym_valid_o;
        end
        check("stream_done", done, 1);
        check("sym_count", n_got, n_exp);
        if (chk_rdy) check("rdy_high", rdy_low, 0);
        byte_valid_i = 1'b0;
        sym_ready_i  = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("no_extra_sym", sym_valid_o, 0);
        @(posedge clk_i);
        #1;
        tx_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [2:0]  mode;
        int          nb;
        logic [63:0] bytes;
        int          ns;
        logic [63:0] syms;
        bit          rdy_high;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   fc;
        int   lc;
        vec_t cur;
        int   m;
        int   nb;

        qam_mode_i   = 3'd4;
        rst_i        = 1'b1;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        sym_ready_i  = 1'b0;

        vecs[0] = '{mode: 3'd4, nb: 3, bytes: 64'hC0C000,         ns: 3, syms: 64'hC00000, rdy_high: 1'b0};
        vecs[1] = '{mode: 3'd0, nb: 1, bytes: 64'hA5,             ns: 2, syms: 64'h0A01,   rdy_high: 1'b1};
        vecs[2] = '{mode: 3'd2, nb: 3, bytes: 64'hFFFFFF,         ns: 4, syms: 64'h3F0F3F0F, rdy_high: 1'b0};
        vecs[3] = '{mode: 3'd1, nb: 5, bytes: 64'h0,              ns: 8, syms: 64'h0,      rdy_high: 1'b0};
        vecs[4] = '{mode: 3'd3, nb: 7, bytes: 64'h0,              ns: 8, syms: 64'h0,      rdy_high: 1'b0};

        do_reset();
        check("rst_sym_valid", sym_valid_o, 0);
        check("rst_sym", sym_o, 0);
        check("rst_byte_ready", byte_ready_o, 1);
        check("rst_fill", dbg_fill_o, 0);

        for (int v = 0; v < 5; v++) begin
            cur = vecs[v];
            do_reset();
            set_mode(cur.mode);
            for (int i = 0; i < cur.nb; i++) tx_q.push_back(cur.bytes[8 * (cur.nb - 1 - i) +: 8]);
            for (int i = 0; i < cur.ns; i++) exp_q.push_back(cur.syms[8 * (cur.ns - 1 - i) +: 8]);
            run_stream(100, 100, 0, cur.rdy_high, fc, lc);
            check("vec_fill_end", dbg_fill_o, 0);
            if (v == 0) begin
                check("latency", fc, 2);
                check("throughput", lc - fc, cur.ns - 1);
            end
        end

        // Backpressure in 16-QAM: output stalled for 5 cycles with bytes offered.
        do_reset();
        set_mode(3'd0);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(255)));
        run_stream(100, 100, 5, 1'b0, fc, lc);

        // Reset with 3 residual bits and I_prev=1, then 256 -> 16-QAM while idle.
        do_reset();
        set_mode(3'd1);
        send(8'h80);
        run_stream(100, 100, 0, 1'b0, fc, lc);
        check("pre_rst_fill", dbg_fill_o, 3);
        do_reset();
        check("mid_rst_sym_valid", sym_valid_o, 0);
        check("mid_rst_sym", sym_o, 0);
        check("mid_rst_byte_ready", byte_ready_o, 1);
        check("mid_rst_fill", dbg_fill_o, 0);
        set_mode(3'd0);
        send(8'hA5);
        run_stream(100, 100, 0, 1'b0, fc, lc);

        // Mode request with residual bits: old m stays until the accumulator drains.
        set_mode(3'd2);
        send(8'hFF);
        run_stream(100, 100, 0, 1'b0, fc, lc);
        check("drain_residual", dbg_fill_o, 2);
        set_mode(3'd0);
        send(8'h00);
        send(8'h00);
        run_stream(100, 100, 0, 1'b0, fc, lc);
        check("drain_empty", dbg_fill_o, 0);
        set_mode(3'd0);
        send(8'hA5);
        run_stream(100, 100, 0, 1'b0, fc, lc);

        // Randomized segments, each a whole number of symbols so modes can change between them.
        for (int s = 0; s < 12; s++) begin
            set_mode(3'($urandom_range(7)));
            m  = model_m;
            nb = m * int'($urandom_range(1, 3));
            for (int i = 0; i < nb; i++) send(8'($urandom_range(255)));
            run_stream(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)), 0, 1'b0, fc, lc);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
